// File: rtl/beamform_accum_if.sv
// ============================================================================
// Module   : beamform_accum_if
// Purpose  : Frame-control, sample and readout bundle for beamform_accum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beamform_accum_if #(
    parameter int NUM_CH   = 2,
    parameter int PTR_LEN  = 4,
    parameter int SAMPLE_W = 3,
    parameter int ACC_W    = 8
);
    logic                         frame_start;
    logic                         frame_end;
    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH*SAMPLE_W-1:0]   ch_sample;
    logic [NUM_CH*PTR_LEN-1:0]    ch_point;
    logic                         ch_ready;
    logic                         rd_en;
    logic [PTR_LEN-1:0]           rd_addr;
    logic [ACC_W-1:0]             rd_data;
    logic                         rd_valid;
    logic                         busy;
    logic                         frame_done;
    logic                         sat_flag;

    modport master (
        output frame_start, frame_end, ch_valid, ch_sample, ch_point, rd_en, rd_addr,
        input  ch_ready, rd_data, rd_valid, busy, frame_done, sat_flag
    );

    modport slave (
        input  frame_start, frame_end, ch_valid, ch_sample, ch_point, rd_en, rd_addr,
        output ch_ready, rd_data, rd_valid, busy, frame_done, sat_flag
    );
endinterface

`default_nettype wire

// File: rtl/beamform_accum.sv
// ============================================================================
// Module   : beamform_accum
// Purpose  : Multi-channel focal-point accumulator with saturating entries,
//            per-frame clear and single-cycle-latency readout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module beamform_accum #(
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 16,
    parameter int PTR_LEN  = 4,
    parameter int SAMPLE_W = 3,
    parameter int ACC_W    = 8
) (
    input  wire logic         Clk,
    input  wire logic         reset,
    beamform_accum_if.slave   bus
);

    localparam int                 c_SUM_W = ACC_W + $clog2(NUM_CH) + 1;
    localparam logic [PTR_LEN-1:0] c_LAST  = PTR_LEN'(DEPTH - 1);
    localparam logic [PTR_LEN:0]   c_DEPTH = (PTR_LEN + 1)'(DEPTH);
    localparam logic [ACC_W-1:0]   c_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    logic [PTR_LEN-1:0]  r_clr_cnt;
    logic [ACC_W-1:0]    r_mem [DEPTH];
    logic [ACC_W-1:0]    r_rd_data;
    logic                r_rd_valid;
    logic                r_frame_done;
    logic                r_sat;

    logic [c_SUM_W-1:0]  w_sum  [DEPTH];
    logic [ACC_W-1:0]    w_next [DEPTH];
    logic                w_any_sat;
    logic                w_rd_in_range;

    // Every entry sums all channels aimed at it, so colliding channels all count;
    // indices at or beyond DEPTH match no entry and simply vanish.
    always_comb begin
        w_any_sat = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            w_sum[e] = c_SUM_W'(r_mem[e]);
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.ch_valid[k] && (bus.ch_point[k*PTR_LEN +: PTR_LEN] == PTR_LEN'(e))) begin
                    w_sum[e] = w_sum[e] + c_SUM_W'(bus.ch_sample[k*SAMPLE_W +: SAMPLE_W]);
                end
            end
            if (|w_sum[e][c_SUM_W-1:ACC_W]) begin
                w_next[e] = c_MAX;
                w_any_sat = 1'b1;
            end else begin
                w_next[e] = w_sum[e][ACC_W-1:0];
            end
        end
    end

    assign w_rd_in_range = ({1'b0, bus.rd_addr} < c_DEPTH);

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_clr_cnt    <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_sat        <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            r_rd_valid   <= 1'b0;

            // Reads only see a stable array; during CLEAR/ACCUM rd_data holds.
            if (bus.rd_en && ((r_state == S_IDLE) || (r_state == S_HOLD))) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= w_rd_in_range ? r_mem[bus.rd_addr] : '0;
            end

            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (bus.frame_start) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                        r_sat     <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (bus.frame_start) begin
                        r_clr_cnt <= '0;
                        r_sat     <= 1'b0;
                    end else begin
                        r_mem[r_clr_cnt] <= '0;
                        if (r_clr_cnt == c_LAST) begin
                            r_state   <= S_ACCUM;
                            r_clr_cnt <= '0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.frame_start) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                        r_sat     <= 1'b0;
                    end else begin
                        for (int e = 0; e < DEPTH; e++) begin
                            r_mem[e] <= w_next[e];
                        end
                        if (w_any_sat) begin
                            r_sat <= 1'b1;
                        end
                        if (bus.frame_end) begin
                            r_state      <= S_HOLD;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (r_state == S_CLEAR) || (r_state == S_ACCUM);
    assign bus.ch_ready   = (r_state == S_ACCUM);
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.sat_flag   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_beamform_accum.sv
// ============================================================================
// Module   : tb_beamform_accum
// Purpose  : Directed self-checking bench for beamform_accum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beamform_accum;

    logic Clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    beamform_accum_if #(.NUM_CH(2), .PTR_LEN(4), .SAMPLE_W(3), .ACC_W(8)) bus ();

    beamform_accum #(
        .NUM_CH(2), .DEPTH(16), .PTR_LEN(4), .SAMPLE_W(3), .ACC_W(8)
    ) u_dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.ch_valid    = '0;
        bus.ch_sample   = '0;
        bus.ch_point    = '0;
        bus.rd_en       = 1'b0;
        bus.rd_addr     = '0;
    endtask

    task automatic drive_ch(input logic [1:0] valid, input logic [2:0] s0, input logic [3:0] p0,
                            input logic [2:0] s1, input logic [3:0] p1);
        bus.ch_valid  = valid;
        bus.ch_sample = {s1, s0};
        bus.ch_point  = {p1, p0};
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en   = 1'b0;
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    // Pulse frame_start and count the cycles ch_ready stays low.
    task automatic start_frame(input string tag);
        int n;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        n = 0;
        while (!bus.ch_ready && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_clear_cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_rd_valid",   32'(bus.rd_valid),   32'd0);
        check("rst_rd_data",    32'(bus.rd_data),    32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_ch_ready",   32'(bus.ch_ready),   32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_sat",        32'(bus.sat_flag),   32'd0);
        read_check("rst_rd5", 4'd5, 8'd0);

        // Basic frame: one sample per channel on distinct points.
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("clr_busy",  32'(bus.busy),     32'd1);
        check("clr_ready", 32'(bus.ch_ready), 32'd0);
        begin
            int n;
            n = 0;
            while (!bus.ch_ready && n < 100) begin
                n++;
                tick();
            end
            check("basic_clear_cycles", 32'(n), 32'd16);
        end
        drive_ch(2'b11, 3'd3, 4'd2, 3'd5, 4'd7);
        bus.frame_end = 1'b1;
        tick();
        idle_inputs();
        check("basic_done",  32'(bus.frame_done), 32'd1);
        check("basic_busy",  32'(bus.busy),       32'd0);
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        check("basic_done_pulse", 32'(bus.frame_done), 32'd0);
        read_check("basic_rd2", 4'd2, 8'd3);
        read_check("basic_rd7", 4'd7, 8'd5);
        read_check("basic_rd3", 4'd3, 8'd0);

        // Collision: both channels on point 4, three cycles of 7+6.
        start_frame("coll");
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd4;
        tick();
        bus.rd_en   = 1'b0;
        check("accum_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("accum_rd_hold",  32'(bus.rd_data),  32'd0);
        drive_ch(2'b11, 3'd7, 4'd4, 3'd6, 4'd4);
        tick();
        tick();
        bus.frame_end = 1'b1;
        tick();
        idle_inputs();
        check("coll_sat", 32'(bus.sat_flag), 32'd0);
        read_check("coll_rd4", 4'd4, 8'd39);
        read_check("coll_rd2", 4'd2, 8'd0);

        // Saturation: 14 per cycle at point 0; 18 cycles = 252, 19 = 266.
        start_frame("sat");
        drive_ch(2'b11, 3'd7, 4'd0, 3'd7, 4'd0);
        for (int i = 0; i < 18; i++) tick();
        check("sat_before", 32'(bus.sat_flag), 32'd0);
        bus.frame_end = 1'b1;
        tick();
        idle_inputs();
        check("sat_after", 32'(bus.sat_flag), 32'd1);
        read_check("sat_rd0", 4'd0, 8'd255);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("sat_cleared", 32'(bus.sat_flag), 32'd0);

        // Reset in the middle of accumulation.
        for (int i = 0; i < 16; i++) tick();
        check("mid_ready", 32'(bus.ch_ready), 32'd1);
        drive_ch(2'b11, 3'd5, 4'd3, 3'd2, 4'd0);
        tick();
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy",     32'(bus.busy),     32'd0);
        check("mrst_ready",    32'(bus.ch_ready), 32'd0);
        check("mrst_rd_data",  32'(bus.rd_data),  32'd0);
        check("mrst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("mrst_sat",      32'(bus.sat_flag), 32'd0);
        read_check("mrst_rd3", 4'd3, 8'd0);
        read_check("mrst_rd0", 4'd0, 8'd0);

        // frame_start and frame_end together in ACCUM: restart wins.
        start_frame("both");
        drive_ch(2'b01, 3'd6, 4'd9, 3'd0, 4'd0);
        tick();
        drive_ch(2'b11, 3'd4, 4'd9, 3'd3, 4'd10);
        bus.frame_start = 1'b1;
        bus.frame_end   = 1'b1;
        tick();
        idle_inputs();
        check("both_no_done", 32'(bus.frame_done), 32'd0);
        check("both_busy",    32'(bus.busy),       32'd1);
        check("both_ready",   32'(bus.ch_ready),   32'd0);
        begin
            int n;
            n = 0;
            while (!bus.ch_ready && n < 100) begin
                n++;
                tick();
            end
            check("both_clear_cycles", 32'(n), 32'd16);
        end
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        check("both_done", 32'(bus.frame_done), 32'd1);
        for (int a = 0; a < 16; a++) begin
            read_check($sformatf("both_rd%0d", a), 4'(a), 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
